// File: rtl/video_raster_gen_pkg.sv
package video_raster_gen_pkg;

  localparam int unsigned PRF_HC_W = 9;
  localparam int unsigned PRF_VC_W = 9;

  typedef enum logic [1:0] {
    MACHINE_S48      = 2'd0,
    MACHINE_S128     = 2'd1,
    MACHINE_S3       = 2'd2,
    MACHINE_PENTAGON = 2'd3
  } machine_t;

  typedef struct packed {
    logic [PRF_HC_W-1:0] h_total;
    logic [PRF_HC_W-1:0] hs_start;
    logic [PRF_HC_W-1:0] hs_end;
    logic [PRF_HC_W-1:0] hb_start;
    logic [PRF_HC_W-1:0] hb_end;
    logic [PRF_VC_W-1:0] v_total;
    logic [PRF_VC_W-1:0] vs_start;
    logic [PRF_VC_W-1:0] vs_end;
    logic [PRF_VC_W-1:0] int_vc;
    logic [PRF_HC_W-1:0] int_hc;
    logic [PRF_HC_W-1:0] int_len;
  } profile_t;

  function automatic profile_t profile_of(input machine_t m);
    profile_t p;
    case (m)
      MACHINE_S48:
        p = '{h_total: 9'd448, hs_start: 9'd334, hs_end: 9'd367,
              hb_start: 9'd322, hb_end: 9'd407, v_total: 9'd312,
              vs_start: 9'd248, vs_end: 9'd256, int_vc: 9'd248,
              int_hc: 9'd0, int_len: 9'd64};
      MACHINE_S128, MACHINE_S3:
        p = '{h_total: 9'd456, hs_start: 9'd338, hs_end: 9'd371,
              hb_start: 9'd322, hb_end: 9'd415, v_total: 9'd311,
              vs_start: 9'd247, vs_end: 9'd255, int_vc: 9'd247,
              int_hc: 9'd0, int_len: 9'd64};
      default:
        p = '{h_total: 9'd448, hs_start: 9'd334, hs_end: 9'd367,
              hb_start: 9'd322, hb_end: 9'd407, v_total: 9'd320,
              vs_start: 9'd248, vs_end: 9'd256, int_vc: 9'd248,
              int_hc: 9'd0, int_len: 9'd72};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/video_raster_gen_raster_counter.sv
module video_raster_gen_raster_counter #(
  parameter int unsigned SUB_W = 2,
  parameter int unsigned HC_W  = 9,
  parameter int unsigned VC_W  = 9
) (
  input  logic                   clk28,
  input  logic                   rst_n,
  input  logic [HC_W-1:0]        h_total,
  input  logic [VC_W-1:0]        v_total,
  output logic [HC_W+SUB_W-1:0]  hc0,
  output logic [VC_W-1:0]        vc,
  output logic [VC_W-1:0]        vc_next,
  output logic                   h_wrap,
  output logic                   frame_wrap
);

  localparam int unsigned H0_W = HC_W + SUB_W;

  logic [H0_W-1:0] h_last;
  logic [VC_W-1:0] v_last;

  assign h_last     = {h_total, {SUB_W{1'b0}}} - H0_W'(1);
  assign v_last     = v_total - VC_W'(1);
  assign h_wrap     = (hc0 == h_last);
  assign vc_next    = (vc == v_last) ? '0 : vc + VC_W'(1);
  assign frame_wrap = h_wrap && (vc == v_last);

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      hc0 <= '0;
      vc  <= '0;
    end else if (h_wrap) begin
      hc0 <= '0;
      vc  <= vc_next;
    end else begin
      hc0 <= hc0 + H0_W'(1);
    end
  end

endmodule

// File: rtl/video_raster_gen.sv
module video_raster_gen
  import video_raster_gen_pkg::*;
#(
  parameter int unsigned SUB_W   = 2,
  parameter int unsigned HC_W    = PRF_HC_W,
  parameter int unsigned VC_W    = PRF_VC_W,
  parameter int unsigned BLINK_W = 5
) (
  input  logic               clk28,
  input  logic               rst_n,
  input  machine_t           machine,
  input  logic               line_int_en,
  input  logic [VC_W-1:0]    line_int_line,
  output logic [HC_W-1:0]    hc,
  output logic [VC_W-1:0]    vc,
  output logic               ck14,
  output logic               ck7,
  output logic               ck35,
  output logic               hsync,
  output logic               vsync,
  output logic               csync,
  output logic               blank,
  output logic               screen_area,
  output logic               even_line,
  output logic [BLINK_W-1:0] blink_cnt,
  output logic               frame_start,
  output logic               int_n,
  output logic               line_int,
  output machine_t           active_machine
);

  logic [HC_W+SUB_W-1:0] hc0;
  logic [VC_W-1:0]       vc_next;
  logic                  h_wrap;
  logic                  frame_wrap;
  profile_t              prof;

  logic                  hsync0;
  logic                  vsync0;
  logic                  hblank0;
  logic                  int0;
  logic [HC_W:0]         int_end;

  assign prof = profile_of(active_machine);

  video_raster_gen_raster_counter #(
    .SUB_W (SUB_W),
    .HC_W  (HC_W),
    .VC_W  (VC_W)
  ) u_counter (
    .clk28      (clk28),
    .rst_n      (rst_n),
    .h_total    (HC_W'(prof.h_total)),
    .v_total    (VC_W'(prof.v_total)),
    .hc0        (hc0),
    .vc         (vc),
    .vc_next    (vc_next),
    .h_wrap     (h_wrap),
    .frame_wrap (frame_wrap)
  );

  assign hc = hc0[HC_W+SUB_W-1:SUB_W];

  assign ck14 = rst_n & hc0[0];
  assign ck7  = rst_n & (&hc0[1:0]);
  assign ck35 = rst_n & (&hc0[2:0]);

  assign screen_area = (vc < VC_W'(192)) && (hc < HC_W'(256));

  assign hsync0  = (hc >= HC_W'(prof.hs_start)) && (hc < HC_W'(prof.hs_end));
  assign hblank0 = (hc >= HC_W'(prof.hb_start)) && (hc < HC_W'(prof.hb_end));
  assign vsync0  = (vc >= VC_W'(prof.vs_start)) && (vc < VC_W'(prof.vs_end));
  assign int_end = {1'b0, HC_W'(prof.int_hc)} + {1'b0, HC_W'(prof.int_len)};
  assign int0    = (vc == VC_W'(prof.int_vc)) && (hc >= HC_W'(prof.int_hc)) &&
                   ({1'b0, hc} < int_end);

  // the registered hsync doubles as the one-cycle-delayed copy used for even_line
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      hsync     <= 1'b0;
      vsync     <= 1'b0;
      csync     <= 1'b1;
      blank     <= 1'b0;
      int_n     <= 1'b1;
      even_line <= 1'b0;
    end else begin
      hsync <= hsync0;
      vsync <= vsync0;
      csync <= ~(hsync0 ^ vsync0);
      blank <= vsync0 || hblank0;
      int_n <= ~int0;
      if (hsync0 && !hsync) even_line <= ~even_line;
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      active_machine <= MACHINE_S48;
      blink_cnt      <= '0;
      frame_start    <= 1'b0;
      line_int       <= 1'b0;
    end else begin
      frame_start <= frame_wrap;
      line_int    <= h_wrap && line_int_en && (vc_next == line_int_line);
      if (frame_wrap) begin
        active_machine <= machine;
        blink_cnt      <= blink_cnt + BLINK_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_video_raster_gen.sv
`timescale 1ns/1ps
module tb_video_raster_gen;
  import video_raster_gen_pkg::*;

  logic       clk28 = 1'b0;
  logic       rst_n;
  machine_t   machine;
  logic       line_int_en;
  logic [8:0] line_int_line;
  logic [8:0] hc;
  logic [8:0] vc;
  logic       ck14, ck7, ck35;
  logic       hsync, vsync, csync, blank, screen_area, even_line;
  logic [4:0] blink_cnt;
  logic       frame_start, int_n, line_int;
  machine_t   active_machine;

  video_raster_gen #(
    .SUB_W   (2),
    .HC_W    (9),
    .VC_W    (9),
    .BLINK_W (5)
  ) dut (
    .clk28          (clk28),
    .rst_n          (rst_n),
    .machine        (machine),
    .line_int_en    (line_int_en),
    .line_int_line  (line_int_line),
    .hc             (hc),
    .vc             (vc),
    .ck14           (ck14),
    .ck7            (ck7),
    .ck35           (ck35),
    .hsync          (hsync),
    .vsync          (vsync),
    .csync          (csync),
    .blank          (blank),
    .screen_area    (screen_area),
    .even_line      (even_line),
    .blink_cnt      (blink_cnt),
    .frame_start    (frame_start),
    .int_n          (int_n),
    .line_int       (line_int),
    .active_machine (active_machine)
  );

  always #5 clk28 = ~clk28;

  int total = 0;
  int bad   = 0;
  int t;
  int n_int, int_t0, n_li, li_t, n_fs, n_el, n_hs, n_vs, n_bl, n_cs0, n_cs11;
  logic el_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_int = 0; int_t0 = -1; n_li = 0; li_t = -1; n_fs = 0; n_el = 0;
    n_hs = 0; n_vs = 0; n_bl = 0; n_cs0 = 0; n_cs11 = 0;
  endtask

  task automatic step();
    @(negedge clk28);
    t++;
    if (!int_n) begin
      if (n_int == 0) int_t0 = t;
      n_int++;
    end
    if (line_int) begin
      n_li++;
      li_t = t;
    end
    if (frame_start) n_fs++;
    if (even_line !== el_prev) n_el++;
    el_prev = even_line;
    if (hsync) n_hs++;
    if (vsync) n_vs++;
    if (blank) n_bl++;
    if (!csync) n_cs0++;
    if (vsync && hsync && csync) n_cs11++;
  endtask

  task automatic run_until(input int target);
    while (t < target) step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hc"}, hc, 0);
    chk({tag, "_vc"}, vc, 0);
    chk({tag, "_syncs"}, {hsync, vsync, csync, blank}, 4'b0010);
    chk({tag, "_ints"}, {int_n, line_int, frame_start, even_line}, 4'b1000);
    chk({tag, "_cks"}, {ck14, ck7, ck35}, 3'b000);
    chk({tag, "_blink"}, blink_cnt, 0);
    chk({tag, "_machine"}, active_machine, MACHINE_S48);
  endtask

  initial begin
    rst_n = 1'b0;
    machine = MACHINE_S48;
    line_int_en = 1'b1;
    line_int_line = 9'd100;
    t = 0;
    el_prev = 1'b0;
    clr();
    repeat (3) @(negedge clk28);
    chk_reset_vals("rst");

    // frame 1: S48, release at a falling edge
    rst_n = 1'b1;
    step();
    chk("ck_t1", {ck14, ck7, ck35}, 3'b100);
    chk("screen_t1", screen_area, 1);
    run_until(3);
    chk("ck_t3", {ck14, ck7, ck35}, 3'b110);
    run_until(7);
    chk("ck_t7", {ck14, ck7, ck35}, 3'b111);
    run_until(8);
    chk("ck_t8", {ck14, ck7, ck35}, 3'b000);
    chk("hc_t8", hc, 2);

    run_until(179200);
    chk("li100_pulse", {line_int, frame_start}, 2'b10);
    chk("li100_vc", vc, 100);
    chk("li100_hc", hc, 0);
    machine = MACHINE_S128;
    line_int_line = 9'd0;
    run_until(179201);
    chk("li100_len", line_int, 0);
    run_until(179200 + 1791);
    chk("sw_hc_end", hc, 447);
    chk("sw_active", active_machine, MACHINE_S48);
    run_until(179200 + 1792);
    chk("sw_vc_next", vc, 101);

    run_until(444417);
    chk("int48_low", int_n, 0);
    chk("screen_v248", screen_area, 0);
    run_until(559103);
    chk("f1_last_hc", hc, 447);
    chk("f1_last_vc", vc, 311);
    chk("f1_active_held", active_machine, MACHINE_S48);
    chk("f1_fs_early", frame_start, 0);
    step();
    chk("f1_fs", frame_start, 1);
    chk("f1_li0", line_int, 1);
    chk("f1_active", active_machine, MACHINE_S128);
    chk("f1_blink", blink_cnt, 1);
    chk("f1_n_fs", n_fs, 1);
    chk("f1_n_li", n_li, 2);
    chk("f1_n_int", n_int, 256);
    chk("f1_int_t0", int_t0, 444417);
    chk("f1_n_el", n_el, 312);
    chk("f1_n_hs", n_hs, 41184);
    chk("f1_n_vs", n_vs, 14336);
    chk("f1_n_bl", n_bl, 117696);
    chk("f1_cs0", n_cs0, 53408);
    chk("f1_cs11", n_cs11, 1056);

    // frame 2: S128, no line interrupt expected for line 400
    clr();
    line_int_line = 9'd400;
    machine = MACHINE_PENTAGON;
    step();
    chk("f2_fs_len", frame_start, 0);
    run_until(559104 + 1823);
    chk("f2_hc_end", hc, 455);
    chk("f2_active", active_machine, MACHINE_S128);
    run_until(559104 + 1824);
    chk("f2_vc1", vc, 1);
    chk("f2_hc0", hc, 0);
    run_until(1126367);
    chk("f2_last_vc", vc, 310);
    step();
    chk("f2_fs", frame_start, 1);
    chk("f2_active_next", active_machine, MACHINE_PENTAGON);
    chk("f2_blink", blink_cnt, 2);
    chk("f2_n_fs", n_fs, 1);
    chk("f2_n_li", n_li, 0);
    chk("f2_n_int", n_int, 256);
    chk("f2_int_t0", int_t0, 1009633);
    chk("f2_n_el", n_el, 311);
    chk("f2_n_hs", n_hs, 41052);
    chk("f2_n_vs", n_vs, 14592);
    chk("f2_n_bl", n_bl, 127308);
    chk("f2_cs0", n_cs0, 53532);
    chk("f2_cs11", n_cs11, 1056);

    // frame 3: Pentagon
    clr();
    run_until(1699807);
    chk("f3_last_vc", vc, 319);
    step();
    chk("f3_fs", frame_start, 1);
    chk("f3_blink", blink_cnt, 3);
    chk("f3_n_fs", n_fs, 1);
    chk("f3_n_int", n_int, 288);
    chk("f3_int_t0", int_t0, 1570785);
    chk("f3_n_el", n_el, 320);
    chk("f3_n_vs", n_vs, 14336);
    chk("f3_n_li", n_li, 0);

    // mid-line asynchronous reset while hsync/blank are active
    run_until(1699808 + 1792 + 1400);
    chk("pre_rst_hsync", {hsync, blank}, 2'b11);
    chk("pre_rst_vc", vc, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async");
    @(negedge clk28);
    rst_n = 1'b1;
    t = 0;
    el_prev = 1'b0;
    clr();
    step();
    chk("post_ck14", ck14, 1);
    chk("post_hc", hc, 0);
    run_until(1792);
    chk("post_vc", vc, 1);
    chk("post_hc_wrap", hc, 0);
    chk("post_active", active_machine, MACHINE_S48);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_raster_gen.md
Name: video_raster_gen

Overview:
Parametrised raster timing generator for the 28 MHz video domain. It produces pixel/T-state clock enables, the horizontal and vertical counters, sync and blank, screen-area window, frame INT, a programmable line interrupt, the even_line toggle and the blink counter. Timing comes from a per-machine profile table. A machine change takes effect only at a frame boundary, so the raster is never torn mid-frame. It drives the screen fetcher, the contention logic and the CPU INT path.

Parameters:
SUB_W, 2, sub-pixel prescale bits (hc0 = {hc, SUB_W bits}); 28 MHz / 2^SUB_W = pixel rate
HC_W, 9, horizontal pixel counter width
VC_W, 9, vertical line counter width
BLINK_W, 5, frame counter width (MSB is the flash phase)

Ports:
clk28  in  1  system clock, 28 MHz
rst_n  in  1  reset; asynchronous, active-low
machine  in  machine_t  requested machine; sampled at frame boundary only
line_int_en  in  1  enable line interrupt
line_int_line  in  VC_W  line on which the line interrupt fires
hc  out  HC_W  pixel column (hc0 upper bits)
vc  out  VC_W  line number
ck14  out  1  one-cycle enable at hc0[0]=1
ck7  out  1  one-cycle enable at hc0[1:0]=3
ck35  out  1  one-cycle enable at hc0[2:0]=7
hsync  out  1  registered horizontal sync, active-high
vsync  out  1  registered vertical sync, active-high
csync  out  1  registered, ~(hsync0 ^ vsync0)
blank  out  1  registered blank
screen_area  out  1  vc<192 && hc<256 (combinational from counters)
even_line  out  1  toggles on each hsync rising edge
blink_cnt  out  BLINK_W  frame counter
frame_start  out  1  one-cycle pulse on the cycle hc0 and vc both wrap
int_n  out  1  frame interrupt, active-low, registered
line_int  out  1  one-cycle line interrupt pulse
active_machine  out  machine_t  profile currently in effect

Behaviour:
- Reset values: hc0=0, vc=0, hsync=0, vsync=0, csync=1, blank=0, int_n=1, line_int=0, even_line=0, blink_cnt=0, frame_start=0, active_machine=MACHINE_S48.
- hc0 increments each clk28. At hc0 == (h_total<<SUB_W)-1: hc0 <= 0, and vc increments, or wraps to 0 at v_total-1.
- Frame boundary is the cycle in which both counters wrap. On that cycle:
  - active_machine <= machine.
  - blink_cnt increments and wraps modulo 2^BLINK_W.
  - frame_start <= 1 on the next edge, held for 1 cycle.
  - A machine change at any other time has no effect until the next boundary.
- Profiles, all values in hc/vc units:
  - S48: h_total 448, hsync [334,367), hblank [322,407), v_total 312, vsync [248,256), int at vc 248, hc 0, length 64.
  - S128/S3: h_total 456, hsync [338,371), hblank [322,415), v_total 311, vsync [247,255), int at vc 247, hc 0, length 64.
  - Pentagon (and any other machine_t value): h_total 448, hsync [334,367), hblank [322,407), v_total 320, vsync [248,256), int at vc 248, hc 0, length 72.
- Sync/blank/int_n: compared combinationally from the counters and the active profile, then registered. Latency is 1 clk28. Windows are half-open [start,end).
- blank = vsync window || hblank window.
- int_n = 0 while vc==int_vc and int_hc <= hc < int_hc+int_len.
- even_line: toggles when internal hsync0 is 1 and its 1-cycle-delayed copy is 0.
- line_int:
  - Pulses for 1 cycle on the edge after the hc0 wrap that enters line L, when line_int_en=1 and L==line_int_line. Both inputs are sampled on the wrap cycle only.
  - line_int_line >= v_total never fires.
  - line_int_line=0 fires on the frame-boundary wrap, coincident with frame_start.
- ck14/ck7/ck35 are combinational decodes of hc0 and are 0 during reset.
- Asynchronous reset mid-frame returns every output to its reset value immediately. Counting restarts at hc0=0 after release.

Decomposition:
- common package: add profile_t struct (h_total, hs_start, hs_end, hb_start, hb_end, v_total, vs_start, vs_end, int_vc, int_hc, int_len) and function profile_of(machine_t) returning the constants above.
- One sub-module is natural: raster_counter (hc0/vc counters with wrap and the frame-boundary strobe). Compare, sync, INT and blink logic stay in the top.

Test Plan:
- Reset released with machine=S48 -> frame_start period exactly 448*4*312 = 559104 clk28; blink_cnt=1 after the first pulse and 0 again after 32 pulses.
- machine switched S48→S128 at vc=100 -> active_machine, line length and v_total are unchanged until frame_start. The next frame measures 456*4*311 = 567264 cycles.
- S48 -> int_n low for exactly 256 clk28, starting 1 cycle after vc=248, hc0=0. Pentagon -> 288 cycles.
- line_int_en=1, line_int_line=100 -> exactly one line_int pulse per frame, 1 cycle after vc becomes 100. line_int_line=400 -> none. line_int_line=0 -> coincides with frame_start.
- Inside the vsync lines, with hsync active -> csync=1. During vsync alone -> csync=0. even_line toggles exactly v_total times per frame.
- rst_n asserted at vc=200 -> all outputs are at reset values in the same cycle. After release, the first frame_start arrives after one full S48 frame.
